// File: rtl/net_pkg.sv
// Shared definitions for the network transmit path.
//   NET_DATA_W    flit payload width
//   NET_KEEP_W    byte-enable width (NET_DATA_W/8)
//   NET_RLIMIT_W  width of rate-limiter config fields and counters
//   net_flit_t    packed flit {data, keep, last}; skid buffers carry this layout
//   skid_occ_e    occupancy states of the 2-entry skid buffer
package net_pkg;

  localparam int NET_DATA_W   = 64;
  localparam int NET_KEEP_W   = 8;
  localparam int NET_RLIMIT_W = 8;

  typedef struct packed {
    logic [NET_DATA_W-1:0] data;
    logic [NET_KEEP_W-1:0] keep;
    logic                  last;
  } net_flit_t;

  localparam int NET_FLIT_W = $bits(net_flit_t);

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_occ_e;

endpackage

// File: rtl/net_skid_buffer.sv
// 2-entry registered ready/valid slice, FIFO order.
// Both push_ready and pop_valid come straight from flops, so there is no
// combinational path from pop_ready back to push_ready.
//   clock, reset           clock, asynchronous active-low reset
//   push_valid/ready/data  upstream handshake (payload W bits)
//   pop_valid/ready/data   downstream handshake; pop_data is the head entry
module net_skid_buffer
  import net_pkg::*;
#(
  parameter int W = NET_FLIT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  logic [W-1:0] ent0_p1;
  logic [W-1:0] ent1_p1;
  skid_occ_e    occ_p1;
  logic         vld_p1;
  logic         not_full_p1;
  logic         push;
  logic         pop;

  assign push_ready = not_full_p1;
  assign pop_valid  = vld_p1;
  assign pop_data   = ent0_p1;
  assign push       = push_valid & not_full_p1;
  assign pop        = vld_p1 & pop_ready;

  // stage p1: entry storage and occupancy; ent0 is always the head
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occ_p1      <= SKID_EMPTY;
      vld_p1      <= 1'b0;
      not_full_p1 <= 1'b1;
      ent0_p1     <= '0;
      ent1_p1     <= '0;
    end else begin
      case (occ_p1)
        SKID_EMPTY: begin
          if (push) begin
            ent0_p1 <= push_data;
            occ_p1  <= SKID_ONE;
            vld_p1  <= 1'b1;
          end
        end
        SKID_ONE: begin
          if (push && pop) begin
            // head leaves and the new flit takes its place; occupancy stays 1
            ent0_p1 <= push_data;
          end else if (push) begin
            ent1_p1     <= push_data;
            occ_p1      <= SKID_FULL;
            not_full_p1 <= 1'b0;
          end else if (pop) begin
            occ_p1 <= SKID_EMPTY;
            vld_p1 <= 1'b0;
          end
        end
        SKID_FULL: begin
          // push is impossible here because push_ready is low
          if (pop) begin
            ent0_p1     <= ent1_p1;
            occ_p1      <= SKID_ONE;
            not_full_p1 <= 1'b1;
          end
        end
        default: begin
          occ_p1      <= SKID_EMPTY;
          vld_p1      <= 1'b0;
          not_full_p1 <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/net_tx_rate_limiter.sv
// NIC transmit gate: admits flits toward the network port only while the
// token bucket holds a token, then forwards them through a 2-entry skid buffer.
//   clock, reset                          clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/keep/last   flits from the NIC send path
//   out_valid/out_ready/out_data/keep/last flits to the network port
//   rlimit_inc     tokens added per refill tick
//   rlimit_period  cycles between ticks (0 behaves as 1)
//   rlimit_size    bucket capacity (0 blocks all traffic)
//   tokens         current token count
// Configuration is used live every cycle. One token is spent per accepted
// flit regardless of keep; packets may be throttled between flits.
module net_tx_rate_limiter
  import net_pkg::*;
#(
  parameter int DATA_W = NET_DATA_W,
  parameter int KEEP_W = NET_KEEP_W,   // must equal DATA_W/8
  parameter int CNT_W  = NET_RLIMIT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last,
  input  logic [CNT_W-1:0]  rlimit_inc,
  input  logic [CNT_W-1:0]  rlimit_period,
  input  logic [CNT_W-1:0]  rlimit_size,
  output logic [CNT_W-1:0]  tokens
);

  // payload layout matches net_flit_t: {data, keep, last}
  localparam int PAY_W = DATA_W + KEEP_W + 1;

  logic [CNT_W-1:0] tokens_p0;
  logic [CNT_W-1:0] pcnt_p0;
  logic [CNT_W-1:0] period_eff;
  logic [CNT_W:0]   tokens_sum;
  logic             tick;
  logic             have_token;
  logic             skid_ready;
  logic             accept;
  logic [PAY_W-1:0] pay_in;
  logic [PAY_W-1:0] pay_out;

  // Clamp the widened token sum to the bucket capacity.
  function automatic logic [CNT_W-1:0] sat_tokens(input logic [CNT_W:0]   t,
                                                   input logic [CNT_W-1:0] cap);
    if (t > {1'b0, cap}) return cap;
    return t[CNT_W-1:0];
  endfunction

  assign period_eff = (rlimit_period == '0) ? CNT_W'(1) : rlimit_period;
  // >= rather than == so a period shrunk below the current count ticks at once
  assign tick       = (pcnt_p0 >= (period_eff - CNT_W'(1)));
  assign have_token = (tokens_p0 != '0);
  assign in_ready   = have_token & skid_ready;
  assign accept     = in_valid & in_ready;

  // accept implies tokens_p0 >= 1, so the subtraction never underflows
  assign tokens_sum = {1'b0, tokens_p0}
                    - {{CNT_W{1'b0}}, accept}
                    + (tick ? {1'b0, rlimit_inc} : {(CNT_W+1){1'b0}});

  // stage p0: token bucket and refill period counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tokens_p0 <= '0;
      pcnt_p0   <= '0;
    end else begin
      tokens_p0 <= sat_tokens(tokens_sum, rlimit_size);
      pcnt_p0   <= tick ? '0 : (pcnt_p0 + CNT_W'(1));
    end
  end

  assign tokens = tokens_p0;
  assign pay_in = {in_data, in_keep, in_last};

  // stage p1: registered output slice
  net_skid_buffer #(
    .W (PAY_W)
  ) u_skid (
    .clock      (clock),
    .reset      (reset),
    .push_valid (in_valid & have_token),
    .push_ready (skid_ready),
    .push_data  (pay_in),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (pay_out)
  );

  assign {out_data, out_keep, out_last} = pay_out;

endmodule

// File: tb/tb_net_tx_rate_limiter.sv
// Bench for net_tx_rate_limiter: directed phases from the test plan followed
// by randomized traffic and configuration, all checked against a token-bucket
// and flit-queue reference model held in this file.
module tb_net_tx_rate_limiter;
  import net_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid, in_ready, in_last;
  logic [63:0] in_data;
  logic [7:0]  in_keep;
  logic        out_valid, out_ready, out_last;
  logic [63:0] out_data;
  logic [7:0]  out_keep;
  logic [7:0]  rlimit_inc, rlimit_period, rlimit_size, tokens;

  always #5 clock = ~clock;

  net_tx_rate_limiter dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_keep       (in_keep),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_keep      (out_keep),
    .out_last      (out_last),
    .rlimit_inc    (rlimit_inc),
    .rlimit_period (rlimit_period),
    .rlimit_size   (rlimit_size),
    .tokens        (tokens)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int        m_tok;
  int        m_pcnt;
  net_flit_t m_q[$];

  // driver state
  int seq       = 0;
  int n_acc     = 0;
  int acc_limit = 0;
  bit o_acc, o_beat;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_flit();
    seq++;
    in_data = {$urandom(), 32'(seq)};
    in_keep = 8'($urandom_range(1, 255));
    in_last = ((seq % 4) == 0);
  endtask

  task automatic model_reset();
    m_tok  = 0;
    m_pcnt = 0;
    m_q.delete();
  endtask

  // compare DUT against the model mid-cycle
  task automatic step();
    @(negedge clock);
    chk("tokens", tokens, m_tok);
    chk("in_ready", in_ready, (m_tok > 0) && (m_q.size() < 2));
    chk("out_valid", out_valid, m_q.size() != 0);
    if (m_q.size() != 0) chk("out_flit", {out_data, out_keep, out_last}, m_q[0]);
    o_acc  = in_valid && in_ready;
    o_beat = out_valid && out_ready;
  endtask

  // predict the effect of the next clock edge, then let it happen
  task automatic advance();
    int        p, t;
    bit        tk, acc, pop;
    net_flit_t f;
    p   = (rlimit_period == 0) ? 1 : int'(rlimit_period);
    tk  = (m_pcnt >= p - 1);
    acc = in_valid && (m_tok > 0) && (m_q.size() < 2);
    pop = (m_q.size() != 0) && out_ready;
    f   = '{data: in_data, keep: in_keep, last: in_last};
    t   = m_tok - int'(acc) + (tk ? int'(rlimit_inc) : 0);
    if (t > int'(rlimit_size)) t = int'(rlimit_size);
    @(posedge clock);
    #1;
    m_tok  = t;
    m_pcnt = tk ? 0 : m_pcnt + 1;
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      m_q.push_back(f);
      n_acc++;
      new_flit();
      if (acc_limit > 0 && n_acc >= acc_limit) in_valid = 1'b0;
    end
  endtask

  task automatic cycle();
    step();
    advance();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  first_acc, first_out, beats, run, best;
    int  hb, pairs, maxtok, burst, pb;
    bit  prev, started, ended, got_ready, lastseen;
    logic [72:0] held;

    in_valid = 0; out_ready = 1; in_data = '0; in_keep = '0; in_last = 0;
    rlimit_inc = 8'd1; rlimit_period = 8'd1; rlimit_size = 8'd8;
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    model_reset();

    // full rate: 16 flits, continuous
    n_acc = 0; acc_limit = 16; new_flit(); in_valid = 1;
    first_acc = -1; first_out = -1; beats = 0; run = 0; best = 0;
    for (int k = 0; k < 24; k++) begin
      step();
      if (k == 0) begin
        chk("rst_tokens", tokens, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_flit", {out_data, out_keep, out_last}, 0);
      end
      if (k == 1) chk("full_tok_cycle1", tokens, 1);
      if (o_acc && first_acc < 0) first_acc = k;
      if (out_valid && first_out < 0) first_out = k;
      if (o_beat) begin
        beats++; run++;
        if (run > best) best = run;
      end else run = 0;
      advance();
    end
    chk("full_first_latency", first_out - first_acc, 1);
    chk("full_beats", beats, 16);
    chk("full_no_bubble_run", best, 16);

    // half rate
    acc_limit = 0; rlimit_period = 8'd2; in_valid = 1;
    repeat (40) cycle();
    hb = 0; pairs = 0; prev = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (o_beat) begin
        hb++;
        if (prev) pairs++;
      end
      prev = o_beat;
      advance();
    end
    chk("half_beats", hb, 8);
    chk("half_back_to_back", pairs, 0);

    // burst saturation
    in_valid = 0; rlimit_inc = 8'd4; rlimit_period = 8'd4; rlimit_size = 8'd8;
    maxtok = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (int'(tokens) > maxtok) maxtok = int'(tokens);
      advance();
    end
    chk("burst_never_above_8", maxtok <= 8, 1);
    step();
    chk("burst_saturated", tokens, 8);
    advance();
    rlimit_period = 8'd64; in_valid = 1;
    burst = 0; started = 0; ended = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (o_acc) begin
        if (!ended) burst++;
        started = 1;
      end else if (started) ended = 1;
      advance();
    end
    chk("burst_len", burst, 8);
    got_ready = 0;
    for (int k = 0; k < 100; k++) begin
      if (!got_ready) begin
        step();
        if (in_ready) got_ready = 1;
        advance();
      end
    end
    chk("burst_refill_ready", got_ready, 1);

    // backpressure
    in_valid = 0; rlimit_inc = 8'd1; rlimit_period = 8'd1;
    repeat (10) cycle();
    in_valid = 1;
    repeat (4) cycle();
    out_ready = 0;
    held = '0;
    for (int j = 0; j < 5; j++) begin
      step();
      if (j == 0) held = {out_data, out_keep, out_last};
      else begin
        chk("bp_hold_flit", {out_data, out_keep, out_last}, held);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
      end
      chk("bp_tokens_flat", tokens, 8);
      advance();
    end
    out_ready = 1;
    repeat (10) cycle();

    // size = 0 blocks everything
    rlimit_size = 8'd0;
    cycle();
    for (int k = 0; k < 20; k++) begin
      step();
      chk("size0_in_ready", in_ready, 0);
      advance();
    end

    // period = 0 acts as period = 1
    rlimit_size = 8'd8; rlimit_period = 8'd0; in_valid = 0;
    step();
    chk("p0_start", tokens, 0);
    advance();
    for (int k = 0; k < 4; k++) cycle();
    step();
    chk("p0_tokens", tokens, 5);
    advance();
    for (int k = 0; k < 10; k++) if (m_tok != 8) cycle();

    // size drop while full
    rlimit_size = 8'd3;
    step();
    chk("drop_pre", tokens, 8);
    advance();
    step();
    chk("size_drop", tokens, 3);
    advance();

    // async reset with two flits buffered
    rlimit_size = 8'd8; rlimit_period = 8'd1; out_ready = 0; in_valid = 1;
    for (int k = 0; k < 20; k++) if (m_q.size() < 2) cycle();
    @(negedge clock);
    chk("rst_fill_ready", in_ready, 0);
    chk("rst_fill_valid", out_valid, 1);
    #1 reset = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_tokens", tokens, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_flit", {out_data, out_keep, out_last}, 0);
    model_reset();
    #1 reset = 1'b1;
    in_valid = 0; out_ready = 1;
    advance();
    seq = ((seq + 3) / 4) * 4;
    n_acc = 0; acc_limit = 4; new_flit(); in_valid = 1;
    pb = 0; lastseen = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (o_beat) begin
        pb++;
        lastseen = out_last;
      end
      advance();
    end
    chk("post_rst_beats", pb, 4);
    chk("post_rst_last", lastseen, 1);

    // randomized traffic and configuration
    acc_limit = 0;
    for (int e = 0; e < 6; e++) begin
      rlimit_inc    = 8'($urandom_range(0, 4));
      rlimit_period = 8'($urandom_range(0, 4));
      rlimit_size   = 8'($urandom_range(0, 9));
      for (int k = 0; k < 60; k++) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 7);
        cycle();
      end
    end
    in_valid = 0; out_ready = 1;
    repeat (5) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/net_tx_rate_limiter.md
Name: net_tx_rate_limiter

Overview:
- NIC-side transmit gate driving the network flit stream (64-bit data, 8-bit keep, last) toward the network endpoint.
- Enforces the token-bucket rate configuration the network endpoint publishes: rlimit_inc, rlimit_period and rlimit_size.
- Output is registered through a 2-entry skid buffer, so no combinational path exists from out_ready to in_ready.
- Sits between the NIC send path and the network port.

Parameters:
- DATA_W, 64, flit data width.
- KEEP_W, 8, byte-enable width; must equal DATA_W/8.
- CNT_W, 8, width of the inc, period and size fields, the token counter and the period counter.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset. Asserted when 0.
- in_valid  in  1  flit from NIC send path is valid.
- in_ready  out  1  flit accepted.
- in_data  in  DATA_W  flit payload.
- in_keep  in  KEEP_W  byte enables.
- in_last  in  1  last flit of packet.
- out_valid  out  1  flit to network is valid.
- out_ready  in  1  network accepts flit.
- out_data  out  DATA_W  flit payload.
- out_keep  out  KEEP_W  byte enables.
- out_last  out  1  last flit of packet.
- rlimit_inc  in  CNT_W  tokens added per period.
- rlimit_period  in  CNT_W  cycles per refill; 0 is treated as 1.
- rlimit_size  in  CNT_W  bucket capacity; 0 blocks all traffic.
- tokens  out  CNT_W  current token count, for debug and verification.

Behaviour:
- Reset values:
  - tokens=0, period counter pcnt=0, skid buffer empty.
  - Outputs: out_valid=0, in_ready=0, out_data/keep/last=0.
  - Asynchronous assertion clears all state immediately. Release is sampled on clock.
- Reset mid-packet: any flits held in the skid buffer are discarded. No partial-packet recovery is performed; the upstream block owns packet framing.
- Refill tick:
  - pcnt counts 0..P-1, where P = max(rlimit_period, 1).
  - tick=1 when pcnt == P-1; pcnt then wraps to 0.
  - If rlimit_period changes so that pcnt >= P-1, the tick fires that cycle and pcnt wraps.
- Admission:
  - accept = in_valid & in_ready.
  - in_ready = (tokens != 0) & skid_not_full.
  - One token is consumed per accepted flit, regardless of in_keep.
- Token update, computed in CNT_W+1 bits:
  - t = tokens - accept + (tick ? rlimit_inc : 0).
  - tokens_next = min(t, rlimit_size).
  - Simultaneous accept and tick apply both terms, then saturate.
  - If rlimit_size falls below the current token count, tokens clamp to the new size on the next clock.
  - Configuration is sampled live every cycle; no latching.
- Skid buffer (net_skid_buffer):
  - 2 entries, FIFO order.
  - out_valid=1 whenever the buffer is non-empty.
  - Accepted flit reaches out_* one cycle after acceptance, which is the minimum latency.
  - skid_not_full is a registered signal.
  - Buffer full and out_ready=0: in_ready=0, out_* held stable.
  - Simultaneous push and pop on a 1-entry buffer keeps occupancy at 1.
- Full-rate configuration (inc=1, period=1, size>=1) sustains one flit per cycle after the first token arrives.
- The block does not enforce packet atomicity; a packet may be throttled between flits.

Decomposition:
- Shared package net_pkg:
  - NET_DATA_W=64, NET_KEEP_W=8, NET_RLIMIT_W=8.
  - Packed flit struct {data, keep, last}.
- One sub-module, net_skid_buffer: 2-entry registered ready/valid slice carrying the flit struct, parameterised by payload width and reused elsewhere on the network path.
- The token bucket and period counter stay in net_tx_rate_limiter.

Test Plan:
- Full rate: inc=1, period=1, size=8, in_valid held high, out_ready=1, 16 flits. Required: after reset, tokens reach 1 at cycle 1. First out_valid appears 1 cycle after first accept. Then 16 consecutive out beats with no bubbles.
- Half rate: inc=1, period=2, size=8, continuous input. Required: out_valid/out_ready handshakes alternate 1/0 in steady state, exactly 8 flits in 16 cycles.
- Burst saturation: inc=4, period=4, size=8, in_valid=0 for 40 cycles. Required: tokens saturate at 8, never 9+. Then an 8-flit back-to-back burst is accepted, followed by in_ready=0 until the next tick.
- Backpressure: out_ready=0 for 5 cycles mid-packet. Required: buffer fills to 2 and in_ready=0. out_data/keep/last stay stable. Token count unchanged while stalled. No flit is lost or duplicated, checked by a scoreboard on data and last.
- Config edges:
  - size=0: in_ready stays 0 forever.
  - period=0: behaves as period=1.
  - size dropped from 8 to 3 while tokens=8: tokens=3 next cycle.
- Async reset mid-packet: reset low for 1 cycle between clock edges while 2 flits are buffered. Required: out_valid=0 and tokens=0 immediately. After release, the next packet passes intact.
